// File: rtl/maze_gen_dfs_pkg.sv
// Shared constants and wall/cell index helpers for the DFS maze carver.
package maze_gen_dfs_pkg;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Horizontal wall above cell (c,r); rows run 0..H, row H is the bottom border.
    function automatic int h_idx(input int c, input int r, input int w);
        return r * w + c;
    endfunction

    // Vertical wall left of cell (c,r); columns run 0..W, column W is the right border.
    function automatic int v_idx(input int c, input int r, input int w);
        return r * (w + 1) + c;
    endfunction

    function automatic int cell_idx(input int c, input int r, input int w);
        return r * w + c;
    endfunction

endpackage

// File: rtl/maze_gen_dfs_lifo.sv
// Parametrised LIFO holding the DFS backtrack path; top-of-stack read is combinational.
module maze_gen_dfs_lifo #(
    parameter int DEPTH = 4,
    parameter int DW = 8,
    localparam int SPW = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           push,
    input  logic           pop,
    input  logic [DW-1:0]  din,
    output logic [DW-1:0]  top,
    output logic [SPW-1:0] sp
);

    logic [DW-1:0]  mem_q [0:DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (clr) begin
            sp_d = '0;
        end else if (push) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[sp_q] <= din;
        end
    end

    // A push into a full stack means the carver lost track of visited cells.
    always_ff @(posedge clk) begin
        if (!rst && push && !clr) begin
            assert (sp_q < SPW'(DEPTH));
        end
    end

    assign top = mem_q[sp_q - SPW'(1)];
    assign sp  = sp_q;

endmodule

// File: rtl/maze_gen_dfs.sv
// Depth-first-search maze carver for a W x H grid with start/done handshake.
//   state     | meaning
//   ST_IDLE   | waiting for start; walls from the last run stay readable
//   ST_INIT   | one cycle: all walls up, visited cleared, start cell marked
//   ST_CARVE  | one step per cycle: carve to a free neighbour, backtrack, or finish
module maze_gen_dfs
    import maze_gen_dfs_pkg::*;
#(
    parameter int W = 10,
    parameter int H = 15,
    parameter int OPEN_BORDER = 0,
    localparam int XW = $clog2(W),
    localparam int YW = $clog2(H)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [XW-1:0]          start_x,
    input  logic [YW-1:0]          start_y,
    input  logic [7:0]             rnd,
    output logic [(H+1)*W-1:0]     h_walls,
    output logic [H*(W+1)-1:0]     v_walls,
    output logic                   busy,
    output logic                   done,
    output logic [XW-1:0]          cur_x,
    output logic [YW-1:0]          cur_y
);

    localparam int NC    = W * H;
    localparam int HN    = (H + 1) * W;
    localparam int VN    = H * (W + 1);
    localparam int DEPTH = NC - 1;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int DW    = XW + YW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_CARVE = 2'd2;

    localparam logic [XW-1:0] X_MAX = XW'(W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

    logic [1:0]    state_q, state_d;
    logic [HN-1:0] h_walls_q, h_walls_d;
    logic [VN-1:0] v_walls_q, v_walls_d;
    logic [NC-1:0] visited_q, visited_d;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d;
    logic          done_q, done_d;

    logic           stk_clr, stk_push, stk_pop;
    logic [DW-1:0]  stk_top;
    logic [SPW-1:0] stk_sp;
    logic [XW-1:0]  top_x;
    logic [YW-1:0]  top_y;

    logic [3:0] valid;
    logic       found;
    logic [1:0] dir;
    logic [1:0] d_try;
    logic       wall_is_h;
    int         cx, cy, nx, ny, widx;

    logic unused_rnd;
    assign unused_rnd = ^rnd[7:2];

    function automatic logic is_free(input logic [NC-1:0] vis, input int x, input int y);
        logic [NC-1:0] sh;
        sh = vis >> cell_idx(x, y, W);
        return ~sh[0];
    endfunction

    maze_gen_dfs_lifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_lifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (stk_clr),
        .push (stk_push),
        .pop  (stk_pop),
        .din  ({cur_x_q, cur_y_q}),
        .top  (stk_top),
        .sp   (stk_sp)
    );

    assign {top_x, top_y} = stk_top;

    always_comb begin
        state_d   = state_q;
        h_walls_d = h_walls_q;
        v_walls_d = v_walls_q;
        visited_d = visited_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        done_d    = 1'b0;
        stk_clr   = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;

        cx = int'(cur_x_q);
        cy = int'(cur_y_q);
        valid[DIR_N] = (cy > 0)     && is_free(visited_q, cx, cy - 1);
        valid[DIR_E] = (cx < W - 1) && is_free(visited_q, cx + 1, cy);
        valid[DIR_S] = (cy < H - 1) && is_free(visited_q, cx, cy + 1);
        valid[DIR_W] = (cx > 0)     && is_free(visited_q, cx - 1, cy);

        // First free direction in the rotated order starting at rnd[1:0].
        found = 1'b0;
        dir   = rnd[1:0];
        for (int k = 0; k < 4; k++) begin
            d_try = rnd[1:0] + 2'(k);
            if (!found && valid[d_try]) begin
                found = 1'b1;
                dir   = d_try;
            end
        end

        nx = cx;
        ny = cy;
        case (dir)
            DIR_N: begin ny = cy - 1; widx = h_idx(cx, cy, W);     wall_is_h = 1'b1; end
            DIR_E: begin nx = cx + 1; widx = v_idx(cx + 1, cy, W); wall_is_h = 1'b0; end
            DIR_S: begin ny = cy + 1; widx = h_idx(cx, cy + 1, W); wall_is_h = 1'b1; end
            default: begin nx = cx - 1; widx = v_idx(cx, cy, W);   wall_is_h = 1'b0; end
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_x_d = (start_x > X_MAX) ? X_MAX : start_x;
                    cur_y_d = (start_y > Y_MAX) ? Y_MAX : start_y;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                h_walls_d = '1;
                v_walls_d = '1;
                visited_d = NC'(1) << cell_idx(cx, cy, W);
                stk_clr   = 1'b1;
                state_d   = ST_CARVE;
            end
            ST_CARVE: begin
                if (found) begin
                    if (wall_is_h) begin
                        h_walls_d = h_walls_q & ~(HN'(1) << widx);
                    end else begin
                        v_walls_d = v_walls_q & ~(VN'(1) << widx);
                    end
                    stk_push  = 1'b1;
                    cur_x_d   = XW'(nx);
                    cur_y_d   = YW'(ny);
                    visited_d = visited_q | (NC'(1) << cell_idx(nx, ny, W));
                end else if (stk_sp != '0) begin
                    stk_pop = 1'b1;
                    cur_x_d = top_x;
                    cur_y_d = top_y;
                end else begin
                    if (OPEN_BORDER != 0) begin
                        h_walls_d = h_walls_q & ~(HN'(1) | (HN'(1) << h_idx(W - 1, H, W)));
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            h_walls_q <= '1;
            v_walls_q <= '1;
            visited_q <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_walls_q <= h_walls_d;
            v_walls_q <= v_walls_d;
            visited_q <= visited_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            done_q    <= done_d;
        end
    end

    assign h_walls = h_walls_q;
    assign v_walls = v_walls_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cur_x   = cur_x_q;
    assign cur_y   = cur_y_q;

endmodule

// File: tb/tb_maze_gen_dfs.sv
// Bench for maze_gen_dfs: exact 2x2 walk, open-border 3x2 and clamped-start 10x15 runs.
module tb_maze_gen_dfs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rnd;
    bit         lfsr_on;

    logic       start_a, busy_a, done_a, cx_a, cy_a;
    logic [0:0] sx_a, sy_a;
    logic [5:0] hw_a, vw_a;

    logic       start_b, busy_b, done_b;
    logic [1:0] sx_b, cx_b;
    logic [0:0] sy_b, cy_b;
    logic [8:0] hw_b;
    logic [7:0] vw_b;

    logic         start_c, busy_c, done_c;
    logic [3:0]   sx_c, sy_c, cx_c, cy_c;
    logic [159:0] hw_c;
    logic [164:0] vw_c;

    maze_gen_dfs #(.W(2), .H(2), .OPEN_BORDER(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .start_x(sx_a), .start_y(sy_a), .rnd(rnd),
        .h_walls(hw_a), .v_walls(vw_a), .busy(busy_a), .done(done_a), .cur_x(cx_a), .cur_y(cy_a));

    maze_gen_dfs #(.W(3), .H(2), .OPEN_BORDER(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .start_x(sx_b), .start_y(sy_b), .rnd(rnd),
        .h_walls(hw_b), .v_walls(vw_b), .busy(busy_b), .done(done_b), .cur_x(cx_b), .cur_y(cy_b));

    maze_gen_dfs #(.W(10), .H(15), .OPEN_BORDER(0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .start_x(sx_c), .start_y(sy_c), .rnd(rnd),
        .h_walls(hw_c), .v_walls(vw_c), .busy(busy_c), .done(done_c), .cur_x(cx_c), .cur_y(cy_c));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Structural maze properties that hold for any carving order.
    function automatic int open_interior(input logic [511:0] hw, input logic [511:0] vw,
                                         input int w, input int h);
        int n = 0;
        for (int r = 1; r < h; r++)
            for (int c = 0; c < w; c++)
                if (!hw[r*w+c]) n++;
        for (int r = 0; r < h; r++)
            for (int c = 1; c < w; c++)
                if (!vw[r*(w+1)+c]) n++;
        return n;
    endfunction

    function automatic int border_holes(input logic [511:0] hw, input logic [511:0] vw,
                                        input int w, input int h, input bit ob);
        int n = 0;
        for (int c = 0; c < w; c++) begin
            if (!hw[c] && !(ob && c == 0)) n++;
            if (!hw[h*w+c] && !(ob && c == w-1)) n++;
        end
        for (int r = 0; r < h; r++) begin
            if (!vw[r*(w+1)]) n++;
            if (!vw[r*(w+1)+w]) n++;
        end
        return n;
    endfunction

    function automatic int reach_cnt(input logic [511:0] hw, input logic [511:0] vw,
                                     input int w, input int h);
        bit seen [0:1023];
        int n = 0;
        seen[0] = 1'b1;
        for (int it = 0; it < w*h; it++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++)
                    if (seen[y*w+x]) begin
                        if (x+1 < w && !vw[y*(w+1)+x+1]) seen[y*w+x+1] = 1'b1;
                        if (x > 0   && !vw[y*(w+1)+x])   seen[y*w+x-1] = 1'b1;
                        if (y+1 < h && !hw[(y+1)*w+x])   seen[(y+1)*w+x] = 1'b1;
                        if (y > 0   && !hw[y*w+x])       seen[(y-1)*w+x] = 1'b1;
                    end
        for (int i = 0; i < w*h; i++) if (seen[i]) n++;
        return n;
    endfunction

    // Scoreboard for the 2x2 instance: busy-run length, done flag and per-cycle position.
    typedef struct { int len; bit dn; } run_t;
    run_t       len_q[$];
    logic [1:0] path_q[$];
    int         exp_q[$];

    task automatic push_run_a();
        logic [1:0] p [8];
        run_t r;
        p = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2, 2'd0};
        r.len = 8;
        r.dn  = 1'b1;
        len_q.push_back(r);
        for (int i = 0; i < 8; i++) path_q.push_back(p[i]);
    endtask

    int run_len = 0;
    bit busy_prev = 1'b0;
    always @(negedge clk) begin
        run_t e;
        if (busy_a) begin
            run_len++;
            if (path_q.size() > 0) check("path_a", 64'({cx_a, cy_a}), 64'(path_q.pop_front()));
        end
        if (busy_prev && !busy_a) begin
            if (len_q.size() > 0) e = len_q.pop_front();
            else begin e.len = -1; e.dn = 1'b0; end
            check("busy_len_a", 64'(run_len), 64'(e.len));
            check("done_at_end_a", 64'(done_a), 64'(e.dn));
            run_len = 0;
        end else begin
            check("done_spurious_a", 64'(done_a), 0);
        end
        busy_prev = busy_a;
    end

    always @(negedge clk) if (lfsr_on) rnd = {rnd[6:0], rnd[7] ^ rnd[5] ^ rnd[4] ^ rnd[3]};

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 100 && done_a !== 1'b1; i++) @(negedge clk);
        check(tag, 64'(done_a), 1);
    endtask

    int cnt;

    initial begin
        rst = 1'b1; rnd = 8'd0; lfsr_on = 1'b0;
        start_a = 1'b0; sx_a = '0; sy_a = '0;
        start_b = 1'b0; sx_b = '0; sy_b = '0;
        start_c = 1'b0; sx_c = '0; sy_c = '0;
        repeat (3) @(negedge clk);

        check("rst_busy_a", 64'(busy_a), 0);
        check("rst_done_a", 64'(done_a), 0);
        check("rst_hw_a", 64'(hw_a), 'h3f);
        check("rst_vw_a", 64'(vw_a), 'h3f);
        check("rst_cur_a", 64'({cx_a, cy_a}), 0);
        check("rst_walls_c", 64'((&hw_c) & (&vw_c)), 1);
        check("rst_busy_bc", 64'(busy_b | busy_c), 0);
        rst = 1'b0;
        @(negedge clk);

        // 2x2, rnd=0, start (0,0): fixed walk and exact wall maps.
        push_run_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("done_seen_a1");
        check("hw_a1", 64'(hw_a), 'b110111);
        check("vw_a1", 64'(vw_a), 'b101101);
        repeat (3) @(negedge clk);
        check("hw_a_hold", 64'(hw_a), 'b110111);
        check("vw_a_hold", 64'(vw_a), 'b101101);

        // start held high: ignored while busy, re-accepted in the done cycle.
        push_run_a();
        push_run_a();
        start_a = 1'b1;
        @(negedge clk);
        wait_done_a("done_seen_a2");
        @(negedge clk);
        check("b2b_busy_a", 64'(busy_a), 1);
        start_a = 1'b0;
        wait_done_a("done_seen_a3");
        check("hw_a3", 64'(hw_a), 'b110111);
        check("vw_a3", 64'(vw_a), 'b101101);
        @(negedge clk);

        // Reset in the fifth busy cycle aborts without done.
        begin
            run_t r;
            r.len = 5;
            r.dn  = 1'b0;
            len_q.push_back(r);
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy_a", 64'(busy_a), 0);
        check("abort_hw_a", 64'(hw_a), 'h3f);
        check("abort_vw_a", 64'(vw_a), 'h3f);
        check("abort_cur_a", 64'({cx_a, cy_a}), 0);
        @(negedge clk);
        push_run_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("done_seen_a4");
        check("hw_a4", 64'(hw_a), 'b110111);
        check("vw_a4", 64'(vw_a), 'b101101);
        @(negedge clk);

        // 3x2 with openings, pseudo-random directions.
        rnd = 8'hA5;
        lfsr_on = 1'b1;
        exp_q.push_back(12);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200 && done_b !== 1'b1; i++) begin
            if (busy_b) cnt++;
            @(negedge clk);
        end
        check("done_seen_b", 64'(done_b), 1);
        check("busy_len_b", 64'(cnt), 64'(exp_q.pop_front()));
        check("entry_open_b", 64'(hw_b[0]), 0);
        check("exit_open_b", 64'(hw_b[8]), 0);
        check("border_b", 64'(border_holes(512'(hw_b), 512'(vw_b), 3, 2, 1'b1)), 0);
        check("open_cnt_b", 64'(open_interior(512'(hw_b), 512'(vw_b), 3, 2)), 5);
        check("reach_b", 64'(reach_cnt(512'(hw_b), 512'(vw_b), 3, 2)), 6);
        @(negedge clk);

        // 10x15 with an out-of-range start that must clamp to the far corner.
        exp_q.push_back(300);
        sx_c = 4'd15;
        sy_c = 4'd15;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000 && done_c !== 1'b1; i++) begin
            if (busy_c) begin
                cnt++;
                if (cnt <= 2) check($sformatf("start_cur_c%0d", cnt), 64'({cx_c, cy_c}), 'h9E);
            end
            @(negedge clk);
        end
        check("done_seen_c", 64'(done_c), 1);
        check("busy_len_c", 64'(cnt), 64'(exp_q.pop_front()));
        check("border_c", 64'(border_holes(512'(hw_c), 512'(vw_c), 10, 15, 1'b0)), 0);
        check("open_cnt_c", 64'(open_interior(512'(hw_c), 512'(vw_c), 10, 15)), 149);
        check("reach_c", 64'(reach_cnt(512'(hw_c), 512'(vw_c), 10, 15)), 150);
        lfsr_on = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/maze_gen_dfs.md
# maze_gen_dfs

Parametrised depth-first-search maze carver for a W×H cell grid. It produces horizontal and vertical wall bitmaps for the maze renderer and player-collision logic. Compared with the fixed 10×15 generator, it adds:
- a start/done handshake,
- a selectable start cell,
- an optional entry/exit opening,
- a deterministic cycle count,
- a clean restart without a global reset.

## Interface
Parameters:
- W, 10, grid width in cells (2..32)
- H, 15, grid height in cells (2..32)
- OPEN_BORDER, 0, when 1, the final cycle clears the top wall of cell (0,0) and the bottom wall of cell (W-1,H-1)
- XW / YW, derived, $clog2(W) / $clog2(H); not overridable

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a new maze; sampled only in IDLE
- start_x  in  XW  start cell column; sampled with start
- start_y  in  YW  start cell row; sampled with start
- rnd  in  8  random byte; only rnd[1:0] is used, sampled every CARVE cycle
- h_walls  out  (H+1)*W  bit r*W+c = wall above cell (c,r); r=H is the bottom border
- v_walls  out  H*(W+1)  bit r*(W+1)+c = wall left of cell (c,r); c=W is the right border
- busy  out  1  high in INIT and CARVE
- done  out  1  one-cycle pulse on completion
- cur_x / cur_y  out  XW / YW  current carve position, for debug and visualisation

## Operation
- States: IDLE, INIT, CARVE.
- IDLE: when start=1, latch start_x/start_y (clamped to W-1/H-1) into cur and go to INIT.
- INIT (1 cycle):
  - set all walls to 1
  - clear visited[W*H]
  - set visited[cur]
  - set stack pointer sp=0
- CARVE, evaluated once per cycle:
  - Direction encoding: 0=N, 1=E, 2=S, 3=W.
  - A direction d is valid when the neighbour is in the grid and not visited.
  - Chosen direction: the first valid one among (rnd+k)%4 for k=0..3.
  - If any direction is valid:
    - clear the shared wall (N: h[y*W+x], S: h[(y+1)*W+x], E: v[y*(W+1)+x+1], W: v[y*(W+1)+x])
    - push cur
    - move cur to the neighbour
    - set visited[neighbour]
  - Else if sp>0: pop into cur.
  - Else (stack empty, no valid direction):
    - if OPEN_BORDER=1, clear h[0] and h[H*W+W-1]
    - pulse done and go to IDLE
- Walls hold their value in IDLE and remain readable until the next INIT.
- start while busy=1 is ignored.
- Result: a spanning tree. Exactly W*H-1 interior walls are removed, and border walls stay 1 (except the OPEN_BORDER openings).

## Timing
- Reset values:
  - state=IDLE
  - h_walls and v_walls all 1
  - busy=0, done=0
  - cur_x=cur_y=0, sp=0
  - visited all 0
- Reset mid-run aborts immediately and restores the reset values; no done pulse is produced.
- start sampled at edge k:
  - busy=1 from k+1
  - INIT occupies cycle k+1
  - CARVE occupies exactly 2·W·H−1 cycles: W·H−1 pushes, W·H−1 pops, and 1 terminal cycle
- On the edge leaving CARVE: busy=0 and done=1 for one cycle. Walls are final in that same cycle.
- Stack capacity is W*H−1 entries. It can never overflow; a push at full capacity is a design error and is flagged by an assertion.
- Wall index arithmetic uses width $clog2((H+1)*(W+1)) to avoid truncation.

## Structure
- maze_pkg.vh holds:
  - direction constants DIR_N/E/S/W
  - wall-index macros H_IDX(c,r), V_IDX(c,r)
- Sub-module maze_lifo: parametrised depth/width LIFO with push, pop, top and sp outputs.
- The top level holds the FSM, the visited vector, direction selection and wall updates.

## Test plan
- W=2,H=2, start (0,0), rnd=0 constant:
  - path (0,0)→(1,0)→(1,1)→(0,1), then 3 pops
  - busy high 8 cycles
  - h_walls=6'b110111, v_walls=6'b101101
  - done one pulse
- W=4,H=4, LFSR rnd: after done, count of cleared interior walls = 15, all border bits 1, BFS from (0,0) reaches all 16 cells.
- OPEN_BORDER=1, W=3,H=2: h_walls[0]=0 and h_walls[8]=0 after done; other border bits 1.
- Reset during CARVE (cycle 5 of run): next cycle busy=0, done=0, all walls 1; a new start then completes normally.
- start asserted repeatedly during busy: ignored, total run length still 2·W·H cycles; back-to-back start in the done cycle begins a new run.
- start_x=W-1, start_y=H-1 on 10×15: first push holds (9,14); run completes in 300 busy cycles.
